// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the
// multicycle controller and the memory port.
interface multicycle_ctrl_if;
  logic mem_read_o;
  logic mem_write_o;
  logic mem_ready_i;

  modport master (
    output mem_read_o,
    output mem_write_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_read_o,
    input  mem_write_o,
    output mem_ready_i
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM:
// FETCH/DECODE/EXEC/MEM/WB with class register.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  multicycle_ctrl_if.master mem_bus,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o,
  output logic        instr_done_o,
  output logic        illegal_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LW, C_SW,
    C_BR, C_JAL, C_JALR
  } cls_e;

  state_e     state_q;
  cls_e       class_q;
  cls_e       class_d;
  logic       legal;
  logic [6:0] op;
  logic [2:0] f3;
  logic       rdy;
  logic       mem_rd;
  logic       mem_wr;
  logic       unused_bits;

  assign op  = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign rdy = mem_bus.mem_ready_i;
  assign unused_bits =
    ^{instr_i[31:15], instr_i[11:7]};

  always_comb begin
    legal   = 1'b1;
    class_d = C_R;
    unique case (1'b1)
      (op == 7'b0110011): class_d = C_R;
      (op == 7'b0010011): class_d = C_IALU;
      (op == 7'b0000011 && f3 == 3'b010):
        class_d = C_LW;
      (op == 7'b0100011 && f3 == 3'b010):
        class_d = C_SW;
      (op == 7'b1100011 && f3[2:1] == 2'b00):
        class_d = C_BR;
      (op == 7'b1101111): class_d = C_JAL;
      (op == 7'b1100111 && f3 == 3'b000):
        class_d = C_JALR;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
      class_q <= C_R;
    end else begin
      unique case (state_q)
        FETCH:
          if (rdy) state_q <= DECODE;
        DECODE:
          if (legal) begin
            class_q <= class_d;
            state_q <= EXEC;
          end else begin
            state_q <= FETCH;
          end
        EXEC:
          unique case (class_q)
            C_BR:        state_q <= FETCH;
            C_LW, C_SW:  state_q <= MEM;
            default:     state_q <= WB;
          endcase
        MEM:
          if (rdy)
            state_q <= (class_q == C_LW) ? WB : FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs are gated by reset so assertion clears them without an edge
  always_comb begin
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    ir_write_o   = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 2'b00;
    wb_sel_o     = 2'd0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    state_o      = 3'd0;
    if (rst_i) begin
      state_o = state_q;
      unique case (state_q)
        FETCH: begin
          mem_rd     = 1'b1;
          ir_write_o = rdy;
        end
        DECODE:
          if (!legal) begin
            illegal_o  = 1'b1;
            pc_write_o = 1'b1;
          end
        EXEC:
          unique case (class_q)
            C_R:    alu_op_o = 2'b10;
            C_IALU: begin
              alu_op_o  = 2'b11;
              alu_src_o = 1'b1;
            end
            C_LW, C_SW: begin
              alu_op_o  = 2'b00;
              alu_src_o = 1'b1;
            end
            C_BR: begin
              alu_op_o     = 2'b01;
              pc_write_o   = 1'b1;
              instr_done_o = 1'b1;
              pc_src_o     = (zero_i ^ f3[0]) ? 2'd1 : 2'd0;
            end
            default: ;
          endcase
        MEM:
          if (class_q == C_LW) begin
            mem_rd = 1'b1;
          end else begin
            mem_wr       = 1'b1;
            pc_write_o   = rdy;
            instr_done_o = rdy;
          end
        WB: begin
          reg_write_o  = 1'b1;
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
          unique case (class_q)
            C_LW:   wb_sel_o = 2'd1;
            C_JAL: begin
              wb_sel_o = 2'd2;
              pc_src_o = 2'd1;
            end
            C_JALR: begin
              wb_sel_o = 2'd2;
              pc_src_o = 2'd2;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_bus.mem_read_o  = mem_rd;
  assign mem_bus.mem_write_o = mem_wr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed table, reset
// sequences and random instructions vs a trace model.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        zero_i;
  logic        pc_write_o;
  logic [1:0]  pc_src_o;
  logic        ir_write_o;
  logic        reg_write_o;
  logic        alu_src_o;
  logic [1:0]  alu_op_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;
  logic        instr_done_o;
  logic        illegal_o;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .zero_i       (zero_i),
    .mem_bus      (bus),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .ir_write_o   (ir_write_o),
    .reg_write_o  (reg_write_o),
    .alu_src_o    (alu_src_o),
    .alu_op_o     (alu_op_o),
    .wb_sel_o     (wb_sel_o),
    .state_o      (state_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rdy;
    logic        zero;
    logic [16:0] o;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    bit          z;
    int          nf;
    int          nm;
    int          lat;
  } vec_t;

  cyc_t exp_q[$];
  vec_t tbl[12];
  int   nerr = 0;
  int   nchk = 0;

  // Field order: state,pcw,pcs,irw,mr,mw,rw,asrc,aop,wbs,done,ill
  function automatic logic [16:0] pk(
    int st, int pcw, int pcs, int irw,
    int mr, int mw, int rw, int asrc,
    int aop, int wbs, int done, int ill);
    return {st[2:0], pcw[0], pcs[1:0], irw[0],
            mr[0], mw[0], rw[0], asrc[0],
            aop[1:0], wbs[1:0], done[0], ill[0]};
  endfunction

  function automatic logic [16:0] dut_o();
    return {state_o, pc_write_o, pc_src_o,
            ir_write_o, bus.mem_read_o,
            bus.mem_write_o, reg_write_o,
            alu_src_o, alu_op_o, wb_sel_o,
            instr_done_o, illegal_o};
  endfunction

  function automatic void put(
    bit rdy, bit z, logic [16:0] o);
    cyc_t c;
    c.rdy  = rdy;
    c.zero = z;
    c.o    = o;
    exp_q.push_back(c);
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction
  function automatic void build(
    logic [31:0] ins, bit z, int nf, int nm);
    logic [6:0] op;
    logic [2:0] f3;
    int k;
    int aop;
    int asrc;
    int wbs;
    int pcs;
    op = ins[6:0];
    f3 = ins[14:12];
    k  = -1;
    if (op == 7'h33) k = 0;
    else if (op == 7'h13) k = 1;
    else if (op == 7'h03 && f3 == 3'd2) k = 2;
    else if (op == 7'h23 && f3 == 3'd2) k = 3;
    else if (op == 7'h63 && f3 < 3'd2) k = 4;
    else if (op == 7'h6F) k = 5;
    else if (op == 7'h67 && f3 == 3'd0) k = 6;
    for (int i = 0; i < nf; i++)
      put(0, rb(), pk(0,0,0,0,1,0,0,0,0,0,0,0));
    put(1, rb(), pk(0,0,0,1,1,0,0,0,0,0,0,0));
    if (k < 0) begin
      put(rb(), rb(), pk(1,1,0,0,0,0,0,0,0,0,0,1));
      return;
    end
    put(rb(), rb(), pk(1,0,0,0,0,0,0,0,0,0,0,0));
    if (k == 4) begin
      pcs = (z ^ f3[0]) ? 1 : 0;
      put(rb(), z, pk(2,1,pcs,0,0,0,0,0,1,0,1,0));
      return;
    end
    aop  = (k == 0) ? 2 : (k == 1) ? 3 : 0;
    asrc = (k >= 1 && k <= 3) ? 1 : 0;
    put(rb(), z, pk(2,0,0,0,0,0,0,asrc,aop,0,0,0));
    if (k == 2 || k == 3) begin
      for (int i = 0; i < nm; i++)
        put(0, rb(),
            pk(3,0,0,0,k==2,k==3,0,0,0,0,0,0));
      if (k == 3) begin
        put(1, rb(), pk(3,1,0,0,0,1,0,0,0,0,1,0));
        return;
      end
      put(1, rb(), pk(3,0,0,0,1,0,0,0,0,0,0,0));
    end
    wbs = (k == 2) ? 1 : (k >= 5) ? 2 : 0;
    pcs = (k == 5) ? 1 : (k == 6) ? 2 : 0;
    put(rb(), rb(), pk(4,1,pcs,0,0,0,1,0,0,wbs,1,0));
  endfunction

  task automatic chk(
    string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  // Enters and leaves at posedge+1
  task automatic run_trace(
    input logic [31:0] ins, output int lat);
    cyc_t e;
    int n;
    lat = 0;
    n   = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      instr_i         = ins;
      bus.mem_ready_i = e.rdy;
      zero_i          = e.zero;
      #1;
      n++;
      chk($sformatf("cyc%0d ins=%h", n, ins),
          {15'd0, dut_o()}, {15'd0, e.o});
      if ((instr_done_o || illegal_o) && lat == 0)
        lat = n;
      @(posedge clk_i);
      #1;
    end
  endtask

  logic [6:0] ops [8];

  initial begin
    int lat;
    logic [31:0] r;
    tbl[0]  = '{32'h002081B3, 0, 0, 0, 4};
    tbl[1]  = '{32'h0000A183, 0, 0, 2, 7};
    tbl[2]  = '{32'h00208463, 1, 0, 0, 3};
    tbl[3]  = '{32'h00209463, 1, 0, 0, 3};
    tbl[4]  = '{32'h000080E7, 0, 0, 0, 4};
    tbl[5]  = '{32'h0000007F, 0, 0, 0, 2};
    tbl[6]  = '{32'h0020A023, 0, 0, 1, 5};
    tbl[7]  = '{32'h00100093, 0, 2, 0, 6};
    tbl[8]  = '{32'h008000EF, 0, 0, 0, 4};
    tbl[9]  = '{32'h0020C463, 0, 0, 0, 2};
    tbl[10] = '{32'h0000B183, 0, 0, 0, 2};
    tbl[11] = '{32'h00208463, 0, 1, 0, 4};
    ops = '{7'h33, 7'h13, 7'h03, 7'h23,
            7'h63, 7'h6F, 7'h67, 7'h7F};

    rst_i           = 1'b0;
    instr_i         = 32'h002081B3;
    zero_i          = 1'b1;
    bus.mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", {15'd0, dut_o()}, 32'd0);
    rst_i           = 1'b1;
    bus.mem_ready_i = 1'b0;
    #1;
    chk("post_reset_fetch", {15'd0, dut_o()},
        {15'd0, pk(0,0,0,0,1,0,0,0,0,0,0,0)});
    @(posedge clk_i);
    #1;

    foreach (tbl[i]) begin
      build(tbl[i].ins, tbl[i].z, tbl[i].nf, tbl[i].nm);
      run_trace(tbl[i].ins, lat);
      chk($sformatf("latency[%0d]", i), lat, tbl[i].lat);
    end

    // Reset asserted mid-store while waiting in MEM
    instr_i         = 32'h0020A023;
    bus.mem_ready_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    bus.mem_ready_i = 1'b0;
    #1;
    chk("sw_in_mem", {15'd0, dut_o()},
        {15'd0, pk(3,0,0,0,0,1,0,0,0,0,0,0)});
    #1;
    rst_i = 1'b0;
    #1;
    chk("reset_async", {15'd0, dut_o()}, 32'd0);
    bus.mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("reset_hold", {15'd0, dut_o()}, 32'd0);
    rst_i           = 1'b1;
    bus.mem_ready_i = 1'b0;
    #1;
    chk("reset_release", {15'd0, dut_o()},
        {15'd0, pk(0,0,0,0,1,0,0,0,0,0,0,0)});
    @(posedge clk_i);
    #1;
    build(32'h002081B3, 0, 0, 0);
    run_trace(32'h002081B3, lat);
    chk("latency_after_reset", lat, 4);

    for (int i = 0; i < 150; i++) begin
      bit z;
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0)
        r[14:12] = 3'($urandom_range(0, 2));
      z = rb();
      build(r, z, $urandom_range(0, 2),
            $urandom_range(0, 2));
      run_trace(r, lat);
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows:
- clk_i, input, 1 bit: clock; all state updates on the rising edge.
- rst_i, input, 1 bit: asynchronous, active-low reset.

REQ-002 The block SHALL have these further ports:
- instr_i, input, 32 bits: instruction register contents; stable from DECODE onward.
- zero_i, input, 1 bit: ALU zero flag, valid in EXEC.
- mem_ready_i, input, 1 bit: memory access completes in the cycle it is high.
- pc_write_o, output, 1 bit: PC load enable.
- pc_src_o, output, 2 bits: PC source. 0 = PC+4, 1 = branch/JAL target, 2 = JALR target.
- ir_write_o, output, 1 bit: instruction register load enable.
- mem_read_o, output, 1 bit: memory read request.
- mem_write_o, output, 1 bit: memory write request.
- reg_write_o, output, 1 bit: register file write enable.
- alu_src_o, output, 1 bit: ALU operand B select. 1 = immediate.
- alu_op_o, output, 2 bits: ALU op. 00 = add, 01 = branch compare, 10 = R-type, 11 = I-type.
- wb_sel_o, output, 2 bits: write-back source. 0 = ALU, 1 = memory, 2 = PC+4.
- state_o, output, 3 bits: current state.
- instr_done_o, output, 1 bit: one-cycle pulse when an instruction retires.
- illegal_o, output, 1 bit: one-cycle pulse when an unsupported instruction is decoded.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.

REQ-004 Any output not explicitly asserted in a given state SHALL be 0.

REQ-005 FETCH SHALL assert mem_read_o, and SHALL hold FETCH while mem_ready_i=0; when mem_ready_i=1 it SHALL assert ir_write_o and go to DECODE.

REQ-006 DECODE SHALL classify instr_i[6:0]/[14:12] into a registered class:
- R: opcode 0110011.
- IALU: opcode 0010011.
- LW: opcode 0000011 with funct3 010.
- SW: opcode 0100011 with funct3 010.
- BR: opcode 1100011 with funct3 000 or 001.
- JAL: opcode 1101111.
- JALR: opcode 1100111 with funct3 000.

REQ-007 Any other encoding in DECODE SHALL assert illegal_o and pc_write_o (pc_src_o=0) and go to FETCH; a legal encoding SHALL go to EXEC.

REQ-008 EXEC SHALL behave per class:
- R: alu_op_o=10, go to WB.
- IALU: alu_op_o=11 and alu_src_o=1, go to WB.
- LW/SW: alu_op_o=00 and alu_src_o=1, go to MEM.
- JAL/JALR: go to WB.

REQ-009 For class BR, EXEC SHALL assert alu_op_o=01, pc_write_o and instr_done_o, and go to FETCH.
- Branch taken = zero_i XOR funct3[0].
- pc_src_o = 1 if taken, else 0.

REQ-010 MEM for class LW SHALL assert mem_read_o and hold MEM until mem_ready_i=1, then go to WB.

REQ-011 MEM for class SW SHALL assert mem_write_o and hold MEM until mem_ready_i=1. In that cycle it SHALL also assert pc_write_o (pc_src_o=0) and instr_done_o, then go to FETCH.

REQ-012 WB SHALL assert reg_write_o, pc_write_o and instr_done_o, then go to FETCH, with wb_sel_o and pc_src_o by class:
- LW: wb_sel_o=1, pc_src_o=0.
- JAL: wb_sel_o=2, pc_src_o=1.
- JALR: wb_sel_o=2, pc_src_o=2.
- Otherwise: wb_sel_o=0, pc_src_o=0.

REQ-013 Instruction latency with mem_ready_i tied high SHALL be:
- R/IALU/JAL/JALR: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BR: 3 cycles.
Each cycle mem_ready_i is low in FETCH or MEM SHALL add one cycle.

REQ-014 instr_done_o SHALL pulse exactly once per retired legal instruction and never for an illegal one.

REQ-015 mem_ready_i SHALL be ignored in DECODE, EXEC and WB.

Reset
REQ-016 While rst_i=0, the block SHALL hold state=FETCH, class register=R, and every output at 0, including state_o=0.

REQ-017 Assertion of rst_i mid-instruction SHALL take effect immediately, without waiting for a clock edge, and SHALL suppress any pending pc_write_o, reg_write_o or mem_write_o.

REQ-018 In the first cycle after rst_i rises, the block SHALL be in FETCH with mem_read_o=1.

Verification
REQ-019 ADD 0x002081B3, mem_ready_i=1 -> states 0,1,2,4; alu_op_o=10 in EXEC; reg_write_o=1, wb_sel_o=0, pc_src_o=0 in WB; one instr_done_o pulse.

REQ-020 LW 0x0000A183, mem_ready_i low for 2 MEM cycles -> MEM lasts 3 cycles with mem_read_o=1; WB has wb_sel_o=1 and reg_write_o=1.

REQ-021 BEQ 0x00208463 with zero_i=1 -> EXEC pc_write_o=1, pc_src_o=1. BNE 0x00209463 with zero_i=1 -> pc_src_o=0. reg_write_o stays 0 throughout both.

REQ-022 JALR 0x000080E7 -> WB has pc_src_o=2, wb_sel_o=2, reg_write_o=1.

REQ-023 Opcode 0x0000007F -> illegal_o pulse in DECODE, next state FETCH, no reg_write_o/instr_done_o.

REQ-024 SW 0x0020A023 with rst_i driven low during MEM -> all outputs 0 immediately, no mem_write_o completion; after release, FETCH with mem_read_o=1.
